ssd_scan_driver: RTL and testbench

- Time-multiplexed scanner for the board's 8-digit common-anode seven-segment display.
- Takes one active-low 7-bit segment pattern per digit, as produced by the per-digit BCD-to-segment decoders. Drives the shared cathode bus and the active-low anode lines.
- Frame updates are double-buffered and applied only at a frame boundary, so a scan never shows a mix of old and new digits.

---
 rtl/ssd_scan_driver_if.sv | 23 ++
 rtl/ssd_scan_driver.sv | 102 ++++++++++
 tb/tb_ssd_scan_driver.sv | 250 +++++++++++++++++++++++++
 3 files changed

// File: rtl/ssd_scan_driver_if.sv
// Frame-load and display-drive signals of the seven-segment scan driver.
// The master side supplies patterns/enables and observes the scan outputs.
interface ssd_scan_driver_if #(
  parameter int unsigned NUM_DIGITS = 8
);
  logic [7*NUM_DIGITS-1:0] seg_in;
  logic [NUM_DIGITS-1:0]   digit_en;
  logic                    load;
  logic                    pending;
  logic                    frame_tick;
  logic [NUM_DIGITS-1:0]   an;
  logic [6:0]              seg_out;

  modport master (
    output seg_in, digit_en, load,
    input  pending, frame_tick, an, seg_out
  );

  modport slave (
    input  seg_in, digit_en, load,
    output pending, frame_tick, an, seg_out
  );
endinterface

// File: rtl/ssd_scan_driver.sv
// Time-multiplexed common-anode 7-segment scanner with frame double-buffering.
// Define SSD_BLANK_EN to blank the first BLANK_CYCLES of every digit slot (anti-ghosting).
module ssd_scan_driver #(
  parameter int unsigned NUM_DIGITS   = 8,
  parameter int unsigned PRESCALE     = 100000,
  parameter int unsigned BLANK_CYCLES = 1000
) (
  input logic               clk,
  input logic               rst,
  ssd_scan_driver_if.slave  bus
);
  localparam int unsigned IdxW   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int unsigned CntMax = (PRESCALE > BLANK_CYCLES) ? PRESCALE : BLANK_CYCLES + 1;
  localparam int unsigned CntW   = $clog2(CntMax);
  localparam int unsigned BufW   = 7 * NUM_DIGITS;

  localparam logic [CntW-1:0] CntLast = CntW'(PRESCALE - 1);
  localparam logic [IdxW-1:0] IdxLast = IdxW'(NUM_DIGITS - 1);

  logic [CntW-1:0]       cnt_q, cnt_d;
  logic [IdxW-1:0]       idx_q, idx_d;
  logic [BufW-1:0]       disp_q, disp_d;
  logic [BufW-1:0]       pend_q, pend_d;
  logic                  pending_q, pending_d;
  logic                  tick_q, tick_d;
  logic [NUM_DIGITS-1:0] an_q, an_d;
  logic [6:0]            seg_q, seg_d;
  logic                  wrap, boundary, blank;

  assign wrap     = (cnt_q == CntLast);
  assign boundary = wrap && (idx_q == IdxLast);

`ifdef SSD_BLANK_EN
  assign blank = (cnt_q < CntW'(BLANK_CYCLES));
`else
  assign blank = 1'b0;
`endif

  always_comb begin
    cnt_d = wrap ? '0 : cnt_q + 1'b1;
    idx_d = idx_q;
    if (wrap) begin
      idx_d = (idx_q == IdxLast) ? '0 : idx_q + 1'b1;
    end
  end

  // A load coinciding with the boundary bypasses pend_q so it is not lost a frame.
  always_comb begin
    disp_d    = disp_q;
    pend_d    = pend_q;
    pending_d = pending_q;
    if (boundary) begin
      if (bus.load) begin
        disp_d    = bus.seg_in;
        pending_d = 1'b0;
      end else if (pending_q) begin
        disp_d    = pend_q;
        pending_d = 1'b0;
      end
    end else if (bus.load) begin
      pend_d    = bus.seg_in;
      pending_d = 1'b1;
    end
  end

  always_comb begin
    tick_d = boundary;
    an_d   = '1;
    seg_d  = 7'h7F;
    if (bus.digit_en[idx_q] && !blank) begin
      an_d  = ~(NUM_DIGITS'(1) << idx_q);
      seg_d = disp_q[int'(idx_q)*7 +: 7];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q     <= '0;
      idx_q     <= '0;
      disp_q    <= '1;
      pend_q    <= '1;
      pending_q <= 1'b0;
      tick_q    <= 1'b0;
      an_q      <= '1;
      seg_q     <= 7'h7F;
    end else begin
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      disp_q    <= disp_d;
      pend_q    <= pend_d;
      pending_q <= pending_d;
      tick_q    <= tick_d;
      an_q      <= an_d;
      seg_q     <= seg_d;
    end
  end

  assign bus.pending    = pending_q;
  assign bus.frame_tick = tick_q;
  assign bus.an         = an_q;
  assign bus.seg_out    = seg_q;
endmodule

// File: tb/tb_ssd_scan_driver.sv
// Self-checking bench for ssd_scan_driver: directed scenarios plus random traffic,
// all checked every cycle against a slot/frame-arithmetic model.
module tb_ssd_scan_driver;
  localparam int N  = 4;
  localparam int P  = 4;
  localparam int BL = 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;

  ssd_scan_driver_if #(.NUM_DIGITS(N)) bus ();

  ssd_scan_driver #(
    .NUM_DIGITS   (N),
    .PRESCALE     (P),
    .BLANK_CYCLES (BL)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Model state: t = rising edges since reset release; slot/digit/frame follow from it.
  int         t = 0;
  logic [6:0] m_disp [N];
  logic [6:0] m_pend [N];
  logic       m_pending = 1'b0;
  logic [3:0] e_an      = 4'hF;
  logic [6:0] e_seg     = 7'h7F;
  logic       e_tick    = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got %0h want %0h", name, $time, act, exp);
    end
  endtask

  initial begin
    for (int k = 0; k < N; k++) begin
      m_disp[k] = 7'h7F;
      m_pend[k] = 7'h7F;
    end
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        t = 0;
        m_pending = 1'b0;
        e_an = 4'hF;
        e_seg = 7'h7F;
        e_tick = 1'b0;
        for (int k = 0; k < N; k++) begin
          m_disp[k] = 7'h7F;
          m_pend[k] = 7'h7F;
        end
      end else begin
        int  idx;
        int  cnt;
        bit  bnd;
        bit  blk;
        idx = (t / P) % N;
        cnt = t % P;
        bnd = (t % (P * N)) == (P * N - 1);
`ifdef SSD_BLANK_EN
        blk = (cnt < BL);
`else
        blk = 1'b0;
`endif
        e_tick = bnd;
        if (bus.digit_en[idx] && !blk) begin
          e_an  = ~(4'b0001 << idx);
          e_seg = m_disp[idx];
        end else begin
          e_an  = 4'hF;
          e_seg = 7'h7F;
        end
        if (bnd) begin
          if (bus.load) begin
            for (int k = 0; k < N; k++) m_disp[k] = bus.seg_in[7*k +: 7];
          end else if (m_pending) begin
            for (int k = 0; k < N; k++) m_disp[k] = m_pend[k];
          end
          m_pending = 1'b0;
        end else if (bus.load) begin
          for (int k = 0; k < N; k++) m_pend[k] = bus.seg_in[7*k +: 7];
          m_pending = 1'b1;
        end
        t++;
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      chk("an", 32'(bus.an), 32'(e_an));
      chk("seg_out", 32'(bus.seg_out), 32'(e_seg));
      chk("frame_tick", 32'(bus.frame_tick), 32'(e_tick));
      chk("pending", 32'(bus.pending), 32'(m_pending));
    end
  end

  // Leaves the bench 1 time unit after the edge that produced the tick.
  task automatic wait_tick(input int expect_n);
    int n;
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (!bus.frame_tick && n < 40);
    chk("tick_seen", 32'(bus.frame_tick), 32'd1);
    if (expect_n > 0) chk("tick_edges", 32'(n), 32'(expect_n));
  endtask

  function automatic bit blank_cyc(input int j);
`ifdef SSD_BLANK_EN
    return (j % P) < BL;
`else
    return 1'b0;
`endif
  endfunction

  logic [3:0] an_tbl [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
  logic [6:0] pat_tbl[4] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110};

  initial begin
    bus.seg_in   = '1;
    bus.digit_en = 4'hF;
    bus.load     = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_an", 32'(bus.an), 32'hF);
    chk("rst_seg", 32'(bus.seg_out), 32'h7F);
    chk("rst_pending", 32'(bus.pending), 32'd0);
    #1 rst = 1'b0;

    // Reset asserted in slot 2 blanks the anodes at once.
    repeat (10) @(posedge clk);
    #2;
    chk("slot2_an", 32'(bus.an), 32'hB);
    rst = 1'b1;
    #1;
    chk("midrst_an", 32'(bus.an), 32'hF);
    chk("midrst_seg", 32'(bus.seg_out), 32'h7F);
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    wait_tick(16);

    // Single load mid-frame, shown from the next frame.
    @(posedge clk);
    #2;
    bus.seg_in = {7'b0000110, 7'b0010010, 7'b1001111, 7'b0000001};
    bus.load   = 1'b1;
    @(posedge clk);
    #1;
    chk("load_pending", 32'(bus.pending), 32'd1);
    chk("load_seg_old", 32'(bus.seg_out), 32'h7F);
    #1 bus.load = 1'b0;
    wait_tick(0);
    chk("bnd_pending", 32'(bus.pending), 32'd0);
    for (int j = 0; j < 16; j++) begin
      @(posedge clk);
      #1;
      if (blank_cyc(j)) begin
        chk("scan_an_blk", 32'(bus.an), 32'hF);
        chk("scan_seg_blk", 32'(bus.seg_out), 32'h7F);
      end else begin
        chk("scan_an", 32'(bus.an), 32'(an_tbl[j/4]));
        chk("scan_seg", 32'(bus.seg_out), 32'(pat_tbl[j/4]));
      end
    end

    // Two loads in one frame: latest wins.
    @(posedge clk);
    #2;
    bus.seg_in = '0;
    bus.load   = 1'b1;
    @(posedge clk);
    #2 bus.load = 1'b0;
    @(posedge clk);
    #2;
    bus.seg_in = {4{7'b1001100}};
    bus.load   = 1'b1;
    @(posedge clk);
    #2 bus.load = 1'b0;
    wait_tick(0);
    chk("two_pending", 32'(bus.pending), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    chk("two_an", 32'(bus.an), 32'hE);
    chk("two_seg", 32'(bus.seg_out), 32'(7'b1001100));

    // Load on the boundary edge itself.
    repeat (13) @(posedge clk);
    #2;
    bus.seg_in = {4{7'b0100100}};
    bus.load   = 1'b1;
    @(posedge clk);
    #1;
    chk("edge_tick", 32'(bus.frame_tick), 32'd1);
    chk("edge_pending", 32'(bus.pending), 32'd0);
    #1 bus.load = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("edge_an", 32'(bus.an), 32'hE);
    chk("edge_seg", 32'(bus.seg_out), 32'(7'b0100100));

    // Digits 1 and 3 disabled.
    #1 bus.digit_en = 4'b0101;
    wait_tick(0);
    for (int j = 0; j < 16; j++) begin
      @(posedge clk);
      #1;
      if ((j / 4) % 2 == 1 || blank_cyc(j)) begin
        chk("en_an_off", 32'(bus.an), 32'hF);
        chk("en_seg_off", 32'(bus.seg_out), 32'h7F);
      end else begin
        chk("en_an_on", 32'(bus.an), 32'(an_tbl[j/4]));
        chk("en_seg_on", 32'(bus.seg_out), 32'(7'b0100100));
      end
    end
    #1 bus.digit_en = 4'hF;

    // Random traffic; the per-cycle compare does the checking.
    for (int c = 0; c < 3000; c++) begin
      @(posedge clk);
      #2;
      bus.load   = ($urandom_range(5) == 0);
      bus.seg_in = 28'($urandom);
      if ($urandom_range(15) == 0) bus.digit_en = 4'($urandom);
      if (rst) rst = 1'b0;
      else if ($urandom_range(399) == 0) rst = 1'b1;
    end
    @(posedge clk);
    #2;
    bus.load = 1'b0;
    rst      = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
